// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types for the PC fetch sequencer: state encoding and counter widths.
package pc_fetch_sequencer_pkg;

    localparam int INSTR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_HALT  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_JUMP  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_fetch_wait_timer.sv
// Memory wait-state counter: cleared before each fetch, counts stalled WAIT cycles,
// flags expiry once the count reaches MAX_WAIT.
module fetch_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clock,
    input  logic notReset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] count_q, count_d;

    assign expired_o = (count_q == WAIT_W'(MAX_WAIT));

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && !expired_o)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction-cycle sequencer driving PC load/OE/increment and memory/IR strobes.
// All outputs decode registered state, except ir_load/pc_inc which follow mem_ready in WAIT.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                   clock,
    input  logic                   notReset,
    input  logic                   run,
    input  logic                   halt_req,
    input  logic                   jump_req,
    input  logic                   exec_done,
    input  logic                   mem_ready,
    output logic                   pc_notClear,
    output logic                   pc_notLoad,
    output logic                   pc_notOE,
    output logic                   pc_inc,
    output logic                   mem_read,
    output logic                   ir_load,
    output logic                   exec_start,
    output logic                   halted,
    output logic                   bus_error,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    fetch_state_e           state_q, state_d;
    logic                   halt_pend_q, halt_pend_d;
    logic                   bus_err_q, bus_err_d;
    logic                   exec_first_q, exec_first_d;
    logic [INSTR_CNT_W-1:0] icnt_q, icnt_d;
    logic                   wait_expired;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clock     (clock),
        .notReset  (notReset),
        .clr_i     (state_q == ST_ADDR),
        .en_i      ((state_q == ST_WAIT) && !mem_ready),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        bus_err_d   = bus_err_q;
        icnt_d      = icnt_q;
        unique case (state_q)
            ST_CLEAR: state_d = ST_HALT;
            ST_HALT: begin
                if (run) begin
                    state_d     = ST_ADDR;
                    bus_err_d   = 1'b0;
                    halt_pend_d = 1'b0;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_EXEC;
                end else if (wait_expired) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (halt_req)
                    halt_pend_d = 1'b1;
                if (exec_done) begin
                    icnt_d = icnt_q + 1'b1;
                    if (jump_req)
                        state_d = ST_JUMP;
                    else if (halt_pend_q || halt_req)
                        state_d = ST_HALT;
                    else
                        state_d = ST_ADDR;
                end
            end
            ST_JUMP: state_d = halt_pend_q ? ST_HALT : ST_ADDR;
            default: state_d = ST_CLEAR;
        endcase
    end

    // exec_start marks only the entry cycle of EXEC, so a multi-cycle execute pulses once.
    assign exec_first_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q      <= ST_CLEAR;
            halt_pend_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            exec_first_q <= 1'b0;
            icnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            halt_pend_q  <= halt_pend_d;
            bus_err_q    <= bus_err_d;
            exec_first_q <= exec_first_d;
            icnt_q       <= icnt_d;
        end
    end

    assign pc_notClear = (state_q != ST_CLEAR);
    assign pc_notLoad  = (state_q != ST_JUMP);
    assign pc_notOE    = !((state_q == ST_ADDR) || (state_q == ST_WAIT));
    assign mem_read    = (state_q == ST_ADDR) || (state_q == ST_WAIT);
    assign ir_load     = (state_q == ST_WAIT) && mem_ready;
    assign pc_inc      = (state_q == ST_WAIT) && mem_ready;
    assign exec_start  = (state_q == ST_EXEC) && exec_first_q;
    assign halted      = (state_q == ST_CLEAR) || (state_q == ST_HALT);
    assign bus_error   = bus_err_q;
    assign instr_count = icnt_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Control sequencer for the 16-bit program counter. Drives the PC's load, output-enable and increment controls and the memory-read and IR-load strobes. Runs the instruction cycle: fetch address, wait for memory, latch instruction, execute, optional jump. Sits between the CPU control FSM (run/halt/jump/exec handshakes) and the PC/memory datapath.

Parameters:
MAX_WAIT, 15, maximum memory wait cycles in FETCH_WAIT before bus error (1..2^WAIT_W-1)
WAIT_W, 4, width of wait-state counter

Ports:
clock  input  1  system clock; all state changes on rising edge
notReset  input  1  asynchronous, active-low reset
run  input  1  level; leave HALT and begin fetching
halt_req  input  1  request halt at end of current instruction; sampled in EXEC
jump_req  input  1  qualified by exec_done; load PC from bus
exec_done  input  1  execution unit finished current instruction
mem_ready  input  1  memory data valid this cycle
pc_notClear  output  1  active-low synchronous clear to PC counters
pc_notLoad  output  1  active-low PC parallel load
pc_notOE  output  1  active-low PC bus output enable
pc_inc  output  1  PC count enable
mem_read  output  1  memory read strobe
ir_load  output  1  instruction register load strobe
exec_start  output  1  one-cycle pulse starting execution
halted  output  1  high in CLEAR/HALT
bus_error  output  1  sticky fetch-timeout flag
instr_count  output  16  retired-instruction counter

Behaviour:
- Reset (notReset low, asynchronous): state=CLEAR, wait counter=0, halt_pending=0, bus_error=0, instr_count=0. Outputs: pc_notClear=0, pc_notLoad=1, pc_notOE=1, pc_inc=0, mem_read=0, ir_load=0, exec_start=0, halted=1.
- All outputs Moore-decoded from registered state/flags, except ir_load/pc_inc in FETCH_WAIT (combinational on mem_ready).
- States:
  - CLEAR: pc_notClear=0; PC clears at next edge. -> HALT unconditionally.
  - HALT: halted=1. run=1 -> ADDR, clear bus_error and halt_pending on that edge.
  - ADDR: pc_notOE=0, mem_read=1, wait counter<=0. -> WAIT.
  - WAIT: pc_notOE=0, mem_read=1. mem_ready=1: ir_load=1, pc_inc=1 same cycle (PC increments at edge) -> EXEC. Else if counter==MAX_WAIT: set bus_error -> HALT, no increment. Else counter+1.
  - EXEC: exec_start=1 on first EXEC cycle only. halt_req=1 any EXEC cycle sets halt_pending. On exec_done: instr_count+1 (wraps FFFF->0000); jump_req=1 -> JUMP; else halt_pending or halt_req -> HALT; else -> ADDR.
  - JUMP: pc_notLoad=0, pc_inc=0, pc_notOE=1 (bus free for target). -> HALT if halt_pending else ADDR.
- pc_notLoad and pc_inc never active together; pc_notOE low only in ADDR/WAIT.
- Fetch latency with mem_ready tied high: ADDR, WAIT, EXEC = minimum 3 cycles/instruction (+1 for jump).
- jump_req/halt_req ignored outside EXEC; run ignored outside HALT. run deassertion mid-instruction has no effect.
- exec_done in first EXEC cycle legal (single-cycle execute).
- Reset mid-fetch: immediate return to CLEAR, strobes drop asynchronously.

Decomposition:
- Shared package: state encoding constants (CLEAR, HALT, ADDR, WAIT, EXEC, JUMP; 3 bits), instr_count width.
- One sub-module: fetch_wait_timer (clear, enable, MAX_WAIT compare, expired output).

Test Plan:
- Reset release, run=0 -> pc_notClear low exactly one cycle, then halted=1, all strobes idle, instr_count=0000.
- run=1, mem_ready=1, exec_done=1 constantly -> repeating ADDR/WAIT/EXEC; pc_inc one cycle per 3; instr_count=0004 after 12 cycles.
- mem_ready delayed 5 cycles -> mem_read/pc_notOE held 6 WAIT cycles, single pc_inc/ir_load pulse coincident with mem_ready.
- mem_ready never (MAX_WAIT=15) -> bus_error=1 after 16 WAIT cycles, halted=1, no pc_inc; run again clears bus_error.
- exec_done with jump_req=1 and halt_req=1 -> one JUMP cycle with pc_notLoad=0, pc_inc=0, then HALT; instr_count +1.
- notReset pulsed low during WAIT -> mem_read, pc_notOE drop without clock edge; sequence restarts from CLEAR.
